// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR pattern generator and its receive-side checker.
// Both ends must agree on the history width and tap mask or the checker never locks.
package lfsr_pkg;

    localparam int LFSR_WIDTH = 4;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAP_MASK = 4'b1110;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

endpackage

// File: rtl/lfsr_checker_if.sv
// Receive-side bundle between the link front end (master) and the LFSR checker (slave).
interface lfsr_checker_if #(
    parameter int CNT_W = 16
);

    logic             in_valid;
    logic             in_bit;
    logic             clear_count;
    logic             locked;
    logic             err_pulse;
    logic             sync_loss;
    logic             stuck_zero;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid,
        output in_bit,
        output clear_count,
        input  locked,
        input  err_pulse,
        input  sync_loss,
        input  stuck_zero,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  clear_count,
        output locked,
        output err_pulse,
        output sync_loss,
        output stuck_zero,
        output err_count
    );

endinterface

// File: rtl/lfsr_next_bit.sv
// Next-bit predictor: parity of the tapped history bits (hist[0] is the newest bit).
// Kept separate so the generator can reuse exactly the same feedback function.
module lfsr_next_bit
    import lfsr_pkg::*;
#(
    parameter int                   WIDTH    = LFSR_WIDTH,
    parameter logic [WIDTH-1:0]     TAP_MASK = LFSR_TAP_MASK
) (
    input  logic [WIDTH-1:0] hist,
    output logic             pred
);

    assign pred = ^(hist & TAP_MASK);

endmodule

// File: rtl/lfsr_checker.sv
// Serial LFSR stream checker: self-synchronises on the received bits, then flywheels on its
// own predictions while LOCKED, counting mismatches and dropping lock after a run of misses.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAP_MASK    = LFSR_TAP_MASK,
    parameter int               LOCK_CNT    = 8,
    parameter int               LOSS_THRESH = 3,
    parameter int               CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    lfsr_checker_if.slave  bus
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THRESH - 1);

    lfsr_state_e        state;
    logic [WIDTH-1:0]   hist;
    logic [WIDTH-1:0]   hist_next;
    logic [FILL_W-1:0]  fill_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic               pred;
    logic               mismatch;
    logic               counted_err;
    logic               locked_r;
    logic               err_pulse_r;
    logic               sync_loss_r;
    logic               stuck_zero_r;
    logic [CNT_W-1:0]   err_count_r;

    lfsr_next_bit #(
        .WIDTH    (WIDTH),
        .TAP_MASK (TAP_MASK)
    ) u_next_bit (
        .hist (hist),
        .pred (pred)
    );

    // While LOCKED the history is fed from the prediction, so a corrupted bit cannot poison it.
    always_comb begin
        mismatch    = (bus.in_bit != pred);
        counted_err = bus.in_valid && (state == LOCKED) && mismatch;
        hist_next   = hist;
        if (bus.in_valid) begin
            hist_next = {hist[WIDTH-2:0], (state == LOCKED) ? pred : bus.in_bit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            hist         <= '0;
            fill_cnt     <= '0;
            match_cnt    <= '0;
            miss_cnt     <= '0;
            locked_r     <= 1'b0;
            err_pulse_r  <= 1'b0;
            sync_loss_r  <= 1'b0;
            stuck_zero_r <= 1'b0;
        end else begin
            err_pulse_r <= 1'b0;
            sync_loss_r <= 1'b0;
            hist        <= hist_next;
            if (bus.in_valid) begin
                unique case (state)
                    FILL: begin
                        if (fill_cnt == FILL_LAST) begin
                            state     <= VERIFY;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (mismatch) begin
                            state    <= FILL;
                            fill_cnt <= '0;
                        end else if (match_cnt == MATCH_LAST) begin
                            state        <= LOCKED;
                            locked_r     <= 1'b1;
                            miss_cnt     <= '0;
                            stuck_zero_r <= (hist_next == '0);
                        end else begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                        end
                    end
                    LOCKED: begin
                        stuck_zero_r <= (hist_next == '0);
                        if (mismatch) begin
                            err_pulse_r <= 1'b1;
                            if (miss_cnt == MISS_LAST) begin
                                state        <= FILL;
                                fill_cnt     <= '0;
                                miss_cnt     <= '0;
                                locked_r     <= 1'b0;
                                sync_loss_r  <= 1'b1;
                                stuck_zero_r <= 1'b0;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state        <= FILL;
                        fill_cnt     <= '0;
                        locked_r     <= 1'b0;
                        stuck_zero_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A clear coinciding with a counted error keeps that error, so the count restarts at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r <= '0;
        end else if (bus.clear_count) begin
            err_count_r <= counted_err ? CNT_W'(1) : '0;
        end else if (counted_err && (err_count_r != '1)) begin
            err_count_r <= err_count_r + CNT_W'(1);
        end
    end

    assign bus.locked     = locked_r;
    assign bus.err_pulse  = err_pulse_r;
    assign bus.sync_loss  = sync_loss_r;
    assign bus.stuck_zero = stuck_zero_r;
    assign bus.err_count  = err_count_r;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: a bit-level generator model and a queue-based
// reference of the sync/flywheel rules drive and judge randomized and directed streams.
module tb_lfsr_checker;

    localparam int M_FILL   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic clk = 1'b0;
    logic rst;
    logic rst2;

    lfsr_checker_if #(.CNT_W(16)) bus();
    lfsr_checker_if #(.CNT_W(2))  bus2();

    lfsr_checker #(.CNT_W(16)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    lfsr_checker #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Generator: first four outputs are the seed stages Q4..Q1, then x[n]=x[n-2]^x[n-3]^x[n-4].
    bit [3:0] g_seed;
    int       g_n;
    bit       g_win[$];

    // Reference model state
    int        m_mode;
    int        m_fill;
    int        m_run;
    int        m_miss;
    bit        m_hist[$];
    bit        m_locked;
    bit        m_err_pulse;
    bit        m_sync_loss;
    bit        m_stuck;
    bit [15:0] m_err;

    task automatic gen_reset(input bit [3:0] seed);
        g_seed = seed;
        g_n    = 0;
        g_win.delete();
    endtask

    task automatic gen_bit(output bit b);
        if (g_n < 4) b = g_seed[3 - g_n];
        else         b = g_win[2] ^ g_win[1] ^ g_win[0];
        g_win.push_back(b);
        if (g_win.size() > 4) void'(g_win.pop_front());
        g_n++;
    endtask

    task automatic model_reset();
        m_mode = M_FILL;
        m_fill = 0;
        m_run  = 0;
        m_miss = 0;
        m_hist.delete();
        for (int i = 0; i < 4; i++) m_hist.push_back(1'b0);
        m_locked    = 1'b0;
        m_err_pulse = 1'b0;
        m_sync_loss = 1'b0;
        m_stuck     = 1'b0;
        m_err       = 16'd0;
    endtask

    task automatic model_shift(input bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endtask

    task automatic model_step(input bit v, input bit b, input bit clr);
        bit p;
        bit counted;
        p           = m_hist[2] ^ m_hist[1] ^ m_hist[0];
        counted     = 1'b0;
        m_err_pulse = 1'b0;
        m_sync_loss = 1'b0;
        if (v) begin
            if (m_mode == M_FILL) begin
                model_shift(b);
                m_fill++;
                if (m_fill == 4) begin
                    m_mode = M_VERIFY;
                    m_run  = 0;
                end
            end else if (m_mode == M_VERIFY) begin
                model_shift(b);
                if (b == p) begin
                    m_run++;
                    if (m_run == 8) begin
                        m_mode = M_LOCKED;
                        m_miss = 0;
                    end
                end else begin
                    m_mode = M_FILL;
                    m_fill = 0;
                end
            end else begin
                model_shift(p);
                if (b != p) begin
                    counted     = 1'b1;
                    m_err_pulse = 1'b1;
                    m_miss++;
                    if (m_miss == 3) begin
                        m_mode      = M_FILL;
                        m_fill      = 0;
                        m_miss      = 0;
                        m_sync_loss = 1'b1;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (clr)                             m_err = counted ? 16'd1 : 16'd0;
        else if (counted && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        m_locked = (m_mode == M_LOCKED);
        m_stuck  = m_locked && !(m_hist[0] | m_hist[1] | m_hist[2] | m_hist[3]);
    endtask

    task automatic beat(input bit v, input bit b, input bit clr);
        bus.in_valid    = v;
        bus.in_bit      = b;
        bus.clear_count = clr;
        @(posedge clk);
        model_step(v, b, clr);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_bit      = 1'b0;
        bus.clear_count = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_bit      = 1'b1;
        bus.clear_count = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if ({bus.locked, bus.err_pulse, bus.sync_loss, bus.stuck_zero, bus.err_count} !== 20'd0) begin
            $display("[TB] FAIL reset_outputs: got l=%b e=%b s=%b z=%b cnt=%0d, need all 0",
                     bus.locked, bus.err_pulse, bus.sync_loss, bus.stuck_zero, bus.err_count);
        end else passed++;
        checks++;
        if (dut.state !== lfsr_pkg::FILL) begin
            $display("[TB] FAIL reset_state: got %0d need %0d", dut.state, lfsr_pkg::FILL);
        end else passed++;
    endtask

    task automatic test_lock_clean();
        bit b;
        int lock_at = 0;
        do_reset();
        gen_reset(4'b1001);
        for (int i = 1; i <= 200; i++) begin
            gen_bit(b);
            beat(1'b1, b, 1'b0);
            checks++;
            if ({bus.locked, bus.err_pulse, bus.sync_loss, bus.stuck_zero, bus.err_count} !==
                {m_locked, m_err_pulse, m_sync_loss, m_stuck, m_err}) begin
                $display("[TB] FAIL lock_clean beat %0d: got l=%b e=%b s=%b z=%b cnt=%0d, need l=%b e=%b s=%b z=%b cnt=%0d",
                         i, bus.locked, bus.err_pulse, bus.sync_loss, bus.stuck_zero, bus.err_count,
                         m_locked, m_err_pulse, m_sync_loss, m_stuck, m_err);
            end else passed++;
            if (lock_at == 0 && bus.locked === 1'b1) lock_at = i;
        end
        checks++;
        if (lock_at !== 12) $display("[TB] FAIL lock_point: got beat %0d need beat 12", lock_at);
        else passed++;
        checks++;
        if (bus.err_count !== 16'd0) $display("[TB] FAIL clean_err_count: got %0d need 0", bus.err_count);
        else passed++;
    endtask

    task automatic test_single_error();
        bit b;
        int pulses = 0;
        int drops  = 0;
        for (int i = 0; i < 5; i++) begin
            gen_bit(b);
            beat(1'b1, b, 1'b0);
        end
        gen_bit(b);
        beat(1'b1, !b, 1'b0);
        checks++;
        if ({bus.err_pulse, bus.locked, bus.err_count} !== {1'b1, 1'b1, 16'd1}) begin
            $display("[TB] FAIL single_err_hit: got e=%b l=%b cnt=%0d, need e=1 l=1 cnt=1",
                     bus.err_pulse, bus.locked, bus.err_count);
        end else passed++;
        for (int i = 0; i < 30; i++) begin
            gen_bit(b);
            beat(1'b1, b, 1'b0);
            if (bus.err_pulse) pulses++;
            if (!bus.locked)   drops++;
        end
        checks++;
        if (pulses !== 0 || drops !== 0) begin
            $display("[TB] FAIL flywheel: got %0d extra pulses and %0d unlocked beats, need 0 and 0", pulses, drops);
        end else passed++;
        checks++;
        if (bus.err_count !== 16'd1) $display("[TB] FAIL single_err_count: got %0d need 1", bus.err_count);
        else passed++;
    endtask

    task automatic test_burst_loss();
        bit b;
        int relock_at = 0;
        gen_bit(b);
        beat(1'b1, b, 1'b1);
        checks++;
        if (bus.err_count !== 16'd0) $display("[TB] FAIL clear_count: got %0d need 0", bus.err_count);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            gen_bit(b);
            beat(1'b1, !b, 1'b0);
            checks++;
            if ({bus.sync_loss, bus.locked, bus.err_pulse, bus.err_count} !==
                {(k == 3), (k != 3), 1'b1, 16'(k)}) begin
                $display("[TB] FAIL burst_err %0d: got s=%b l=%b e=%b cnt=%0d, need s=%b l=%b e=1 cnt=%0d",
                         k, bus.sync_loss, bus.locked, bus.err_pulse, bus.err_count, (k == 3), (k != 3), k);
            end else passed++;
        end
        for (int i = 1; i <= 40; i++) begin
            gen_bit(b);
            beat(1'b1, b, 1'b0);
            checks++;
            if ({bus.locked, bus.err_pulse, bus.sync_loss, bus.stuck_zero, bus.err_count} !==
                {m_locked, m_err_pulse, m_sync_loss, m_stuck, m_err}) begin
                $display("[TB] FAIL relock beat %0d: got l=%b e=%b s=%b cnt=%0d, need l=%b e=%b s=%b cnt=%0d",
                         i, bus.locked, bus.err_pulse, bus.sync_loss, bus.err_count,
                         m_locked, m_err_pulse, m_sync_loss, m_err);
            end else passed++;
            if (relock_at == 0 && bus.locked === 1'b1) relock_at = i;
        end
        checks++;
        if (relock_at !== 12) $display("[TB] FAIL relock_point: got beat %0d need beat 12", relock_at);
        else passed++;
    endtask

    task automatic test_clear_collision();
        bit b;
        gen_bit(b);
        beat(1'b1, !b, 1'b0);
        checks++;
        if (bus.err_count !== 16'd4) $display("[TB] FAIL pre_clear_count: got %0d need 4", bus.err_count);
        else passed++;
        gen_bit(b);
        beat(1'b1, !b, 1'b1);
        checks++;
        if ({bus.err_pulse, bus.err_count} !== {1'b1, 16'd1}) begin
            $display("[TB] FAIL clear_collision: got e=%b cnt=%0d, need e=1 cnt=1", bus.err_pulse, bus.err_count);
        end else passed++;
        gen_bit(b);
        beat(1'b1, b, 1'b0);
        checks++;
        if ({bus.locked, bus.err_count} !== {1'b1, 16'd1}) begin
            $display("[TB] FAIL after_collision: got l=%b cnt=%0d, need l=1 cnt=1", bus.locked, bus.err_count);
        end else passed++;
    endtask

    task automatic test_random_gaps();
        bit b;
        bit v;
        int valid_n    = 0;
        int lock_valid = 0;
        do_reset();
        gen_reset(4'($urandom_range(1, 15)));
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(0, 1) == 1);
            if (v) begin
                gen_bit(b);
                valid_n++;
            end else begin
                b = 1'($urandom);
            end
            beat(v, b, 1'b0);
            checks++;
            if ({bus.locked, bus.err_pulse, bus.sync_loss, bus.stuck_zero, bus.err_count} !==
                {m_locked, m_err_pulse, m_sync_loss, m_stuck, m_err}) begin
                $display("[TB] FAIL gaps cycle %0d: got l=%b e=%b s=%b z=%b cnt=%0d, need l=%b e=%b s=%b z=%b cnt=%0d",
                         i, bus.locked, bus.err_pulse, bus.sync_loss, bus.stuck_zero, bus.err_count,
                         m_locked, m_err_pulse, m_sync_loss, m_stuck, m_err);
            end else passed++;
            if (lock_valid == 0 && bus.locked === 1'b1) lock_valid = valid_n;
        end
        checks++;
        if (lock_valid !== 12) $display("[TB] FAIL gaps_lock_point: got %0d valid beats need 12", lock_valid);
        else passed++;
        checks++;
        if (bus.err_count !== 16'd0) $display("[TB] FAIL gaps_err_count: got %0d need 0", bus.err_count);
        else passed++;
    endtask

    task automatic test_random_errors();
        bit b;
        bit v;
        bit inv;
        bit clr;
        do_reset();
        gen_reset(4'($urandom_range(1, 15)));
        for (int i = 0; i < 800; i++) begin
            v   = ($urandom_range(0, 9) < 8);
            inv = ($urandom_range(0, 11) == 0);
            clr = ($urandom_range(0, 29) == 0);
            if (v) gen_bit(b);
            else   b = 1'($urandom);
            beat(v, b ^ inv, clr);
            checks++;
            if ({bus.locked, bus.err_pulse, bus.sync_loss, bus.stuck_zero, bus.err_count} !==
                {m_locked, m_err_pulse, m_sync_loss, m_stuck, m_err}) begin
                $display("[TB] FAIL random cycle %0d: got l=%b e=%b s=%b z=%b cnt=%0d, need l=%b e=%b s=%b z=%b cnt=%0d",
                         i, bus.locked, bus.err_pulse, bus.sync_loss, bus.stuck_zero, bus.err_count,
                         m_locked, m_err_pulse, m_sync_loss, m_stuck, m_err);
            end else passed++;
        end
    endtask

    task automatic test_stuck_zero();
        bit b;
        do_reset();
        gen_reset(4'b0000);
        for (int i = 0; i < 12; i++) begin
            gen_bit(b);
            beat(1'b1, b, 1'b0);
        end
        checks++;
        if ({bus.locked, bus.stuck_zero} !== 2'b11) begin
            $display("[TB] FAIL stuck_zero: got l=%b z=%b, need l=1 z=1", bus.locked, bus.stuck_zero);
        end else passed++;
        gen_bit(b);
        beat(1'b1, !b, 1'b0);
        checks++;
        if ({bus.locked, bus.stuck_zero, bus.err_count} !== {1'b1, 1'b1, 16'd1}) begin
            $display("[TB] FAIL stuck_zero_err: got l=%b z=%b cnt=%0d, need l=1 z=1 cnt=1",
                     bus.locked, bus.stuck_zero, bus.err_count);
        end else passed++;
        rst             = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_bit      = 1'b1;
        bus.clear_count = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if ({bus.locked, bus.err_pulse, bus.sync_loss, bus.stuck_zero, bus.err_count} !== 20'd0) begin
            $display("[TB] FAIL midrun_reset: got l=%b e=%b s=%b z=%b cnt=%0d, need all 0",
                     bus.locked, bus.err_pulse, bus.sync_loss, bus.stuck_zero, bus.err_count);
        end else passed++;
        checks++;
        if (dut.state !== lfsr_pkg::FILL) $display("[TB] FAIL midrun_reset_state: got %0d need %0d", dut.state, lfsr_pkg::FILL);
        else passed++;
    endtask

    task automatic test_saturation();
        bit b;
        int exp_cnt;
        rst2             = 1'b1;
        bus2.in_valid    = 1'b0;
        bus2.in_bit      = 1'b0;
        bus2.clear_count = 1'b0;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        gen_reset(4'b1001);
        for (int i = 0; i < 12; i++) begin
            gen_bit(b);
            bus2.in_valid = 1'b1;
            bus2.in_bit   = b;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus2.locked !== 1'b1) $display("[TB] FAIL sat_lock: got %b need 1", bus2.locked);
        else passed++;
        for (int k = 1; k <= 4; k++) begin
            exp_cnt = (k < 3) ? k : 3;
            gen_bit(b);
            bus2.in_bit = !b;
            @(posedge clk);
            #1;
            checks++;
            if ({bus2.locked, bus2.err_count} !== {1'b1, 2'(exp_cnt)}) begin
                $display("[TB] FAIL saturate %0d: got l=%b cnt=%0d, need l=1 cnt=%0d",
                         k, bus2.locked, bus2.err_count, exp_cnt);
            end else passed++;
            gen_bit(b);
            bus2.in_bit = b;
            @(posedge clk);
            #1;
        end
        bus2.in_valid = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        rst2             = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_bit       = 1'b0;
        bus.clear_count  = 1'b0;
        bus2.in_valid    = 1'b0;
        bus2.in_bit      = 1'b0;
        bus2.clear_count = 1'b0;
        model_reset();
        test_reset();
        test_lock_clean();
        test_single_error();
        test_burst_loss();
        test_clear_collision();
        test_random_gaps();
        test_random_errors();
        test_stuck_zero();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
